// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery exponentiation controller.
//   state_e    : main square-and-multiply sequencer states
//   op_phase_e : multiplier handshake phases (idle / reset pulse / wait)
//   WIDTH_DEF  : default operand width
package mont_pkg;

  localparam int WIDTH_DEF = 512;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    SQR,
    MUL,
    NEXT,
    POST,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_RST,
    OP_WAIT
  } op_phase_e;

endpackage

// File: rtl/mont_mul_port.sv
// Handshake front-end to the external Montgomery multiplier.
// One op: a single cycle with mul_resetn_o low and operands loaded, then
// mul_start_o held high until mul_done_i is seen; the product is forwarded
// combinationally on that same edge via ack_o/product_o.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   issue_i, a_i, b_i     request an op with operands (accepted only when idle_o)
//   idle_o                port ready for a new issue
//   ack_o, product_o      op completes this cycle; product valid with ack_o
//   mul_resetn_o, mul_start_o, mul_a_o, mul_b_o   multiplier drive
//   mul_done_i, mul_result_i                      multiplier response
module mont_mul_port
  import mont_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             idle_o,
  output logic             ack_o,
  output logic [WIDTH-1:0] product_o,
  output logic             mul_resetn_o,
  output logic             mul_start_o,
  output logic [WIDTH-1:0] mul_a_o,
  output logic [WIDTH-1:0] mul_b_o,
  input  logic             mul_done_i,
  input  logic [WIDTH-1:0] mul_result_i
);

  op_phase_e        phase_q, phase_d;
  logic             resetn_q, resetn_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= OP_IDLE;
      resetn_q <= 1'b0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      phase_q  <= phase_d;
      resetn_q <= resetn_d;
      start_q  <= start_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    resetn_d = resetn_q;
    start_d  = start_q;
    a_d      = a_q;
    b_d      = b_q;
    case (phase_q)
      OP_IDLE: begin
        // Multiplier is released from reset between ops so each issue
        // produces exactly one low cycle.
        resetn_d = 1'b1;
        start_d  = 1'b0;
        if (issue_i) begin
          a_d      = a_i;
          b_d      = b_i;
          resetn_d = 1'b0;
          phase_d  = OP_RST;
        end
      end
      OP_RST: begin
        resetn_d = 1'b1;
        start_d  = 1'b1;
        phase_d  = OP_WAIT;
      end
      OP_WAIT: begin
        if (mul_done_i) begin
          start_d = 1'b0;
          phase_d = OP_IDLE;
        end
      end
      default: phase_d = OP_IDLE;
    endcase
  end

  // mul_done is only honoured while waiting; a stale high level during
  // the reset-pulse cycle cannot complete the next op.
  assign ack_o        = (phase_q == OP_WAIT) && mul_done_i;
  assign product_o    = mul_result_i;
  assign idle_o       = (phase_q == OP_IDLE);
  assign mul_resetn_o = resetn_q;
  assign mul_start_o  = start_q;
  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply controller computing x^e mod m through
// one external Montgomery multiplier (mont(a,b) = a*b*R^-1 mod m).
// Sequence: xt = mont(x, R^2), A = R mod m, then for every exponent bit from
// MSB to LSB: A = mont(A,A), and if the bit is set A = mont(A,xt); finally
// result = mont(A,1). All WIDTH bits are walked, no leading-zero skip.
// Ports:
//   clk, resetn                           clock, async active-low reset
//   start, modulus, rmodm, rsqmodm,
//   exponent, x                           command and operands (latched on accept)
//   busy, done, result                    status and x^e mod m
//   mul_resetn, mul_start, mul_a, mul_b,
//   mul_m, mul_done, mul_result           multiplier interface
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] rmodm,
  input  logic [WIDTH-1:0] rsqmodm,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mul_resetn,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_m,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_result
);

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // running A (Montgomery domain)
  logic [WIDTH-1:0] xt_q, xt_d;       // x in Montgomery domain
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] rsq_q, rsq_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             op_state;
  logic [WIDTH-1:0] op_a, op_b;
  logic             port_idle, ack;
  logic [WIDTH-1:0] product;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      bit_q    <= CW'(WIDTH-1);
      acc_q    <= '0;
      xt_q     <= '0;
      m_q      <= '0;
      e_q      <= '0;
      x_q      <= '0;
      rsq_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      acc_q    <= acc_d;
      xt_q     <= xt_d;
      m_q      <= m_d;
      e_q      <= e_d;
      x_q      <= x_d;
      rsq_q    <= rsq_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    acc_d    = acc_q;
    xt_d     = xt_q;
    m_d      = m_q;
    e_d      = e_q;
    x_d      = x_q;
    rsq_d    = rsq_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    op_state = 1'b0;
    op_a     = acc_q;
    op_b     = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = modulus;
          e_d     = exponent;
          x_d     = x;
          rsq_d   = rsqmodm;
          acc_d   = rmodm;          // 1 in Montgomery form
          bit_d   = CW'(WIDTH-1);
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        op_state = 1'b1;
        op_a     = x_q;
        op_b     = rsq_q;
        if (ack) begin
          xt_d    = product;
          state_d = SQR;
        end
      end
      SQR: begin
        op_state = 1'b1;
        if (ack) begin
          acc_d   = product;
          state_d = e_q[bit_q] ? MUL : NEXT;
        end
      end
      MUL: begin
        op_state = 1'b1;
        op_b     = xt_q;
        if (ack) begin
          acc_d   = product;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (bit_q == '0) begin
          state_d = POST;
        end else begin
          bit_d   = bit_q - CW'(1);
          state_d = SQR;
        end
      end
      POST: begin
        op_state = 1'b1;
        op_b     = WIDTH'(1);       // leave Montgomery domain
        if (ack) begin
          // Publish on the final capture edge so done follows it by one cycle.
          acc_d    = product;
          result_d = product;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each op state issues once: the port is idle only on the first cycle of
  // the state (the state always changes on ack).
  mont_mul_port #(.WIDTH(WIDTH)) u_port (
    .clk          (clk),
    .rst_n        (resetn),
    .issue_i      (op_state && port_idle),
    .a_i          (op_a),
    .b_i          (op_b),
    .idle_o       (port_idle),
    .ack_o        (ack),
    .product_o    (product),
    .mul_resetn_o (mul_resetn),
    .mul_start_o  (mul_start),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_done_i   (mul_done),
    .mul_result_i (mul_result)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign mul_m  = m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl at WIDTH=8 (m=0xC5, R mod m=0x3B,
// R^2 mod m=0x84) with a behavioural Montgomery multiplier of random latency.
module tb_mont_exp_ctrl;

  localparam int W = 8;
  localparam int M = 197;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [W-1:0] modulus, rmodm, rsqmodm, exponent, x;
  logic         busy, done;
  logic [W-1:0] result;
  logic         mul_resetn, mul_start;
  logic [W-1:0] mul_a, mul_b, mul_m;
  logic         mul_done;
  logic [W-1:0] mul_result;

  mont_exp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .modulus(modulus),
    .rmodm(rmodm), .rsqmodm(rsqmodm), .exponent(exponent), .x(x),
    .busy(busy), .done(done), .result(result),
    .mul_resetn(mul_resetn), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_m(mul_m), .mul_done(mul_done), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Montgomery product with R = 2^8 (bit-serial REDC).
  function automatic int mont(input int a, input int b);
    int t;
    t = a * b;
    for (int k = 0; k < W; k++) begin
      if (t[0]) t = t + M;
      t = t >>> 1;
    end
    if (t >= M) t = t - M;
    return t;
  endfunction

  // Multiplier model and handshake monitors (all at negedge)
  int   ops, rises, pulses, bad_pulse, mbad, low_run;
  int   hold_len = 1, hold_left = 0, cnt = 0, done_cyc = 0;
  bit   active = 1'b0, start_prev = 1'b0;
  int   ma, mb;

  initial begin
    mul_done = 1'b0; mul_result = '0;
    ops = 0; rises = 0; pulses = 0; bad_pulse = 0; mbad = 0; low_run = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        active = 1'b0; hold_left = 0; mul_done = 1'b0; low_run = 0;
      end else begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) mul_done = 1'b0;
        end
        if (!mul_resetn) begin
          active = 1'b0;
          low_run++;
        end else begin
          if (low_run > 0) begin
            pulses++;
            if (low_run != 1) bad_pulse++;
            low_run = 0;
          end
          if (mul_start && !start_prev) rises++;
          if (active) begin
            if (cnt <= 1) begin
              mul_done   = 1'b1;
              mul_result = W'(mont(ma, mb));
              hold_left  = hold_len;
              active     = 1'b0;
              done_cyc   = cyc;
            end else cnt--;
          end else if (mul_start && !mul_done) begin
            active = 1'b1;
            ops++;
            ma = int'(mul_a); mb = int'(mul_b);
            if (mul_m != W'(M)) mbad++;
            cnt = $urandom_range(20, 1);
          end
        end
        start_prev = mul_start;
      end
    end
  end

  logic [W-1:0] last_r = '0;

  task automatic begin_run(input logic [W-1:0] xv, input logic [W-1:0] ev);
    @(negedge clk);
    ops = 0; rises = 0; pulses = 0; bad_pulse = 0; mbad = 0;
    x = xv; exponent = ev; modulus = 8'hC5; rmodm = 8'h3B; rsqmodm = 8'h84;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("result_held", result, last_r);
    // Scramble inputs: they must have been latched.
    x = W'($urandom); exponent = W'($urandom); modulus = W'($urandom);
    rmodm = W'($urandom); rsqmodm = W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done, 1);
    chk("done_latency", cyc - done_cyc, 1);
  endtask

  task automatic check_run(input string tag, input logic [W-1:0] exp_r, input int exp_ops);
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ops"}, ops, exp_ops);
    chk({tag, "_start_rises"}, rises, exp_ops);
    chk({tag, "_rst_pulses"}, pulses, exp_ops);
    chk({tag, "_rst_pulse_len"}, bad_pulse, 0);
    chk({tag, "_mul_m"}, mbad, 0);
    last_r = exp_r;
  endtask

  task automatic do_run(input string tag, input logic [W-1:0] xv, input logic [W-1:0] ev,
                        input logic [W-1:0] exp_r, input int exp_ops);
    begin_run(xv, ev);
    wait_done(3000);
    check_run(tag, exp_r, exp_ops);
  endtask

  initial begin
    int n;
    resetn = 1'b0; start = 1'b0;
    modulus = '0; rmodm = '0; rsqmodm = '0; exponent = '0; x = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_resetn", mul_resetn, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_mul_m", mul_m, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // 5^3 mod 197 = 125; ops = 8 + 2 + 2
    do_run("x5e3", 8'h05, 8'h03, 8'h7D, 12);
    // e = 0 -> 1; ops = 8 + 0 + 2
    do_run("x5e0", 8'h05, 8'h00, 8'h01, 10);
    // e = 1 -> x; ops = 8 + 1 + 2
    do_run("x7e1", 8'h07, 8'h01, 8'h07, 11);
    // x = 0 with all-ones exponent; ops = 8 + 8 + 2
    do_run("x0eFF", 8'h00, 8'hFF, 8'h00, 18);

    // start re-pulsed mid-run with different operands must be ignored
    begin_run(8'h05, 8'h03);
    repeat (20) @(negedge clk);
    chk("midrun_busy_before", busy, 1);
    x = 8'h07; exponent = 8'h01; rmodm = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrun_busy_after", busy, 1);
    wait_done(3000);
    check_run("midrun", 8'h7D, 12);

    // async reset during the squaring phase aborts immediately
    begin_run(8'h05, 8'h03);
    n = 0;
    while (ops < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_sqr", (ops >= 3), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mul_start", mul_start, 0);
    chk("abort_mul_resetn", mul_resetn, 0);
    chk("abort_result", result, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    last_r = '0;
    repeat (3) @(negedge clk);
    do_run("rerun", 8'h05, 8'h03, 8'h7D, 12);

    // mul_done held for 3 cycles: exactly one capture per op
    hold_len = 3;
    do_run("hold3", 8'h05, 8'h03, 8'h7D, 12);
    hold_len = 1;

    repeat (3) @(negedge clk);
    chk("done_level_held", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
